// File: rtl/exu_completion_scheduler.sv
// Issue/completion scheduler for fixed-latency execution units: reserves writeback slots,
// captures unit results into an output FIFO. Define EXU_INORDER_EN to force in-order completion.
module exu_completion_scheduler #(
    parameter int                     DATA_W     = 32,
    parameter int                     NUM_UNITS  = 3,
    parameter int                     SEL_W      = 2,
    parameter int                     TAG_W      = 4,
    parameter int                     MAX_LAT    = 8,
    parameter logic [4*NUM_UNITS-1:0] UNIT_LAT   = {4'd6, 4'd4, 4'd1},
    parameter int                     FIFO_DEPTH = 4
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic                        iIssueValid,
    output logic                        oIssueReady,
    input  logic [SEL_W-1:0]            iIssueUnit,
    input  logic [TAG_W-1:0]            iIssueTag,
    output logic [NUM_UNITS-1:0]        oUnitFire,
    input  logic [NUM_UNITS*DATA_W-1:0] iUnitResult,
    input  logic [NUM_UNITS*3-1:0]      iUnitFlags,
    output logic                        oResValid,
    input  logic                        iResReady,
    output logic [DATA_W-1:0]           oResData,
    output logic [TAG_W-1:0]            oResTag,
    output logic [SEL_W-1:0]            oResUnit,
    output logic [2:0]                  oResFlags,
    output logic                        oBusy
);

    localparam int          RW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int          LW      = $clog2(MAX_LAT + 1);
    localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam int          EW      = 3 + SEL_W + TAG_W + DATA_W;
    localparam logic [31:0] DEPTH_U = FIFO_DEPTH;

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_lat_chk
        if (UNIT_LAT[g*4 +: 4] == 4'd0 || int'(UNIT_LAT[g*4 +: 4]) > MAX_LAT) begin : g_bad
            $fatal(1, "UNIT_LAT entry outside 1..MAX_LAT");
        end
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_bad
        $fatal(1, "FIFO_DEPTH must be a power of two >= 2");
    end
    if ((1 << SEL_W) < NUM_UNITS) begin : g_sel_bad
        $fatal(1, "SEL_W too narrow for NUM_UNITS");
    end

    // Unit codes beyond NUM_UNITS complete after one cycle with a zero result.
    function automatic logic [LW-1:0] lat_of(input logic [SEL_W-1:0] unit);
        logic [LW-1:0] lat;
        lat = LW'(1);
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (unit == SEL_W'(u)) lat = LW'(UNIT_LAT[u*4 +: 4]);
        end
        return lat;
    endfunction

    // Countdown table: an entry captures its unit's result when remaining reaches zero.
    logic [MAX_LAT-1:0] ent_vld_q, ent_vld_d;
    logic [SEL_W-1:0]   ent_unit_q [MAX_LAT];
    logic [SEL_W-1:0]   ent_unit_d [MAX_LAT];
    logic [TAG_W-1:0]   ent_tag_q  [MAX_LAT];
    logic [TAG_W-1:0]   ent_tag_d  [MAX_LAT];
    logic [RW-1:0]      ent_rem_q  [MAX_LAT];
    logic [RW-1:0]      ent_rem_d  [MAX_LAT];

    logic [EW-1:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [LW-1:0]      issue_lat;
    logic [RW-1:0]      issue_rem;
    logic [LW-1:0]      inflight;
    logic               slot_busy;
    logic               order_block;
    logic               credit_ok;
    logic               accept;
    logic               cap_hit;
    logic [SEL_W-1:0]   cap_unit;
    logic [TAG_W-1:0]   cap_tag;
    logic [DATA_W-1:0]  cap_data;
    logic [2:0]         cap_flags;
    logic [RW-1:0]      alloc_idx;
    logic               alloc_found;
    logic               push;
    logic               pop;
    logic [EW-1:0]      head;

    always_comb begin
        issue_lat   = lat_of(iIssueUnit);
        issue_rem   = RW'(issue_lat - LW'(1));
        inflight    = '0;
        slot_busy   = 1'b0;
        order_block = 1'b0;
        cap_hit     = 1'b0;
        cap_unit    = '0;
        cap_tag     = '0;
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (ent_vld_q[i]) begin
                inflight = inflight + LW'(1);
                if (LW'(ent_rem_q[i]) == issue_lat) slot_busy = 1'b1;
                if (LW'(ent_rem_q[i]) >= issue_lat) order_block = 1'b1;
                if (ent_rem_q[i] == '0) begin
                    cap_hit  = 1'b1;
                    cap_unit = ent_unit_q[i];
                    cap_tag  = ent_tag_q[i];
                end
            end
            // A capturing entry frees its slot this cycle, so it may be reused.
            if (!alloc_found && (!ent_vld_q[i] || ent_rem_q[i] == '0)) begin
                alloc_found = 1'b1;
                alloc_idx   = RW'(i);
            end
        end

        // Capturing entries still count against credit; their FIFO push lands at cycle end.
        credit_ok = (32'(inflight) + 32'(cnt_q)) < DEPTH_U;
`ifdef EXU_INORDER_EN
        oIssueReady = !iRst && !slot_busy && credit_ok && !order_block;
`else
        oIssueReady = !iRst && !slot_busy && credit_ok;
`endif
        accept = iIssueValid && oIssueReady;

        oUnitFire = '0;
        cap_data  = '0;
        cap_flags = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (accept && iIssueUnit == SEL_W'(u)) oUnitFire[u] = 1'b1;
            if (cap_hit && cap_unit == SEL_W'(u)) begin
                cap_data  = iUnitResult[u*DATA_W +: DATA_W];
                cap_flags = iUnitFlags[u*3 +: 3];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_LAT; i++) begin
            ent_vld_d[i]  = ent_vld_q[i] && (ent_rem_q[i] != '0);
            ent_rem_d[i]  = ent_rem_q[i] - RW'(1);
            ent_unit_d[i] = ent_unit_q[i];
            ent_tag_d[i]  = ent_tag_q[i];
        end
        if (accept) begin
            ent_vld_d[alloc_idx]  = 1'b1;
            ent_rem_d[alloc_idx]  = issue_rem;
            ent_unit_d[alloc_idx] = iIssueUnit;
            ent_tag_d[alloc_idx]  = iIssueTag;
        end

        push     = cap_hit;
        pop      = (cnt_q != '0) && iResReady;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) cnt_d = cnt_q + CW'(1);
        if (!push && pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            ent_vld_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            ent_vld_q <= ent_vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by ent_vld_q and cnt_q.
    always_ff @(posedge iClk) begin
        ent_unit_q <= ent_unit_d;
        ent_tag_q  <= ent_tag_d;
        ent_rem_q  <= ent_rem_d;
        if (push) fifo_mem_q[wr_ptr_q] <= {cap_flags, cap_unit, cap_tag, cap_data};
    end

    always_comb begin
        head      = fifo_mem_q[rd_ptr_q];
        oResValid = (cnt_q != '0);
        {oResFlags, oResUnit, oResTag, oResData} = oResValid ? head : '0;
        oBusy     = (|ent_vld_q) || (cnt_q != '0);
    end

endmodule

// File: tb/tb_exu_completion_scheduler.sv
// Randomised bench for exu_completion_scheduler against a completion-time queue model.
module tb_exu_completion_scheduler;

    localparam int DATA_W     = 32;
    localparam int NUM_UNITS  = 3;
    localparam int SEL_W      = 2;
    localparam int TAG_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int LAT [NUM_UNITS] = '{1, 4, 6};

    logic                        iClk = 1'b0;
    logic                        iRst = 1'b1;
    logic                        iIssueValid = 1'b0;
    logic                        oIssueReady;
    logic [SEL_W-1:0]            iIssueUnit = '0;
    logic [TAG_W-1:0]            iIssueTag = '0;
    logic [NUM_UNITS-1:0]        oUnitFire;
    logic [NUM_UNITS*DATA_W-1:0] iUnitResult = '0;
    logic [NUM_UNITS*3-1:0]      iUnitFlags = '0;
    logic                        oResValid;
    logic                        iResReady = 1'b1;
    logic [DATA_W-1:0]           oResData;
    logic [TAG_W-1:0]            oResTag;
    logic [SEL_W-1:0]            oResUnit;
    logic [2:0]                  oResFlags;
    logic                        oBusy;

    exu_completion_scheduler dut (
        .iClk(iClk), .iRst(iRst), .iIssueValid(iIssueValid), .oIssueReady(oIssueReady),
        .iIssueUnit(iIssueUnit), .iIssueTag(iIssueTag), .oUnitFire(oUnitFire),
        .iUnitResult(iUnitResult), .iUnitFlags(iUnitFlags), .oResValid(oResValid),
        .iResReady(iResReady), .oResData(oResData), .oResTag(oResTag),
        .oResUnit(oResUnit), .oResFlags(oResFlags), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        int done;
        int unit;
        int tag;
    } op_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic [SEL_W-1:0]  unit;
        logic [2:0]        flags;
    } res_t;

    op_t  pend[$];
    res_t outq[$];
    int   cyc = 0;
    bit   last_acc;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // An op issued now completes at cyc+lat; that slot must be free and credit available.
    function automatic bit model_ready(input int u);
        int lat;
        lat = (u < NUM_UNITS) ? LAT[u] : 1;
        if (pend.size() + outq.size() >= FIFO_DEPTH) return 1'b0;
        foreach (pend[i]) begin
            if (pend[i].done == cyc + lat) return 1'b0;
`ifdef EXU_INORDER_EN
            if (pend[i].done - cyc >= lat) return 1'b0;
`endif
        end
        return 1'b1;
    endfunction

    task automatic step(input logic v, input logic [SEL_W-1:0] u, input logic [TAG_W-1:0] t,
                        input logic rdy, input logic r);
        bit               exp_rdy;
        logic [NUM_UNITS-1:0] exp_fire;
        res_t             rr;
        int               hit;
        iRst        = r;
        iIssueValid = v;
        iIssueUnit  = u;
        iIssueTag   = t;
        iResReady   = rdy;
        iUnitResult = {$urandom(), $urandom(), $urandom()};
        iUnitFlags  = 9'($urandom());
        @(negedge iClk);
        exp_rdy  = !r && model_ready(int'(u));
        exp_fire = '0;
        if (v && exp_rdy && int'(u) < NUM_UNITS) exp_fire[u] = 1'b1;
        chk("issue_ready", 64'(oIssueReady), 64'(exp_rdy));
        chk("unit_fire", 64'(oUnitFire), 64'(exp_fire));
        chk("res_valid", 64'(oResValid), 64'(outq.size() != 0));
        if (outq.size() != 0) begin
            chk("res_data", 64'(oResData), 64'(outq[0].data));
            chk("res_tag", 64'(oResTag), 64'(outq[0].tag));
            chk("res_unit", 64'(oResUnit), 64'(outq[0].unit));
            chk("res_flags", 64'(oResFlags), 64'(outq[0].flags));
        end
        chk("busy", 64'(oBusy), 64'(pend.size() != 0 || outq.size() != 0));
        @(posedge iClk);
        last_acc = 1'b0;
        if (r) begin
            pend.delete();
            outq.delete();
        end else begin
            last_acc = v && exp_rdy;
            if (outq.size() != 0 && rdy) void'(outq.pop_front());
            hit = -1;
            foreach (pend[i]) if (pend[i].done == cyc) hit = i;
            if (hit >= 0) begin
                if (pend[hit].unit < NUM_UNITS) begin
                    rr.data  = iUnitResult[pend[hit].unit*DATA_W +: DATA_W];
                    rr.flags = iUnitFlags[pend[hit].unit*3 +: 3];
                end else begin
                    rr.data  = '0;
                    rr.flags = '0;
                end
                rr.tag  = TAG_W'(pend[hit].tag);
                rr.unit = SEL_W'(pend[hit].unit);
                outq.push_back(rr);
                pend.delete(hit);
            end
            if (last_acc)
                pend.push_back('{done: cyc + ((int'(u) < NUM_UNITS) ? LAT[u] : 1),
                                 unit: int'(u), tag: int'(t)});
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic issue_hold(input logic [SEL_W-1:0] u, input logic [TAG_W-1:0] t);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, u, t, 1'b1, 1'b0);
            if (last_acc) break;
        end
    endtask

    initial begin
        step(1'b0, '0, '0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        chk("rst_ready", 64'(oIssueReady), 64'(0));
        chk("rst_valid", 64'(oResValid), 64'(0));
        chk("rst_busy", 64'(oBusy), 64'(0));
        chk("rst_fire", 64'(oUnitFire), 64'(0));
        chk("rst_data", 64'(oResData), 64'(0));
        chk("rst_tag", 64'(oResTag), 64'(0));
        chk("rst_unit", 64'(oResUnit), 64'(0));
        chk("rst_flags", 64'(oResFlags), 64'(0));
        idle(2);

        step(1'b1, 2'd0, 4'd3, 1'b1, 1'b0);
        idle(4);

        step(1'b1, 2'd1, 4'd1, 1'b1, 1'b0);
        idle(2);
        issue_hold(2'd0, 4'd2);
        idle(8);

        step(1'b1, 2'd1, 4'd1, 1'b1, 1'b0);
        issue_hold(2'd0, 4'd2);
        idle(8);

        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, TAG_W'(i + 4), 1'b0, 1'b0);
        step(1'b0, 2'd0, '0, 1'b0, 1'b0);
        step(1'b0, 2'd0, '0, 1'b1, 1'b0);
        step(1'b0, 2'd0, '0, 1'b0, 1'b0);
        idle(6);

        step(1'b1, 2'd3, 4'd9, 1'b1, 1'b0);
        idle(4);

        step(1'b1, 2'd1, 4'd5, 1'b1, 1'b0);
        idle(1);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        idle(8);

        for (int i = 0; i < 3000; i++) begin
            step(1'b1 && ($urandom_range(0, 9) < 7), SEL_W'($urandom_range(0, 3)),
                 TAG_W'($urandom()), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 199) == 0));
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exu_completion_scheduler.md
Name: exu_completion_scheduler

Overview:
- Parametrised issue/completion front-end for the execution stage.
- Accepts tagged operations for NUM_UNITS fixed-latency pipelined units (ALU, MDU, FPU, ...) and fires the selected unit.
- Reserves writeback slots so two units never complete in the same cycle, and captures each unit result into an output FIFO drained through a valid/ready port.
- Replaces the single registered result mux with credit-based backpressure, per-unit latency and result tags.

Parameters:
- DATA_W, 32: result width.
- NUM_UNITS, 3: number of attached units, index 0..NUM_UNITS-1.
- SEL_W, 2: unit-select width.
- TAG_W, 4: operation tag width.
- MAX_LAT, 8: largest permitted unit latency.
- UNIT_LAT, {4'd6,4'd4,4'd1}: packed 4-bit latency per unit; unit 0 is the low nibble. Each value must be 1..MAX_LAT; elaboration fails otherwise.
- FIFO_DEPTH, 4: output FIFO entries, power of two.

Ports:
- iClk  in  1  clock; all state changes on its rising edge.
- iRst  in  1  synchronous, active-high reset.
- iIssueValid  in  1  issue request.
- oIssueReady  out  1  issue may be accepted this cycle.
- iIssueUnit  in  SEL_W  target unit.
- iIssueTag  in  TAG_W  operation tag.
- oUnitFire  out  NUM_UNITS  one-hot launch strobe to units.
- iUnitResult  in  NUM_UNITS*DATA_W  unit result buses, unit u at [u*DATA_W +: DATA_W].
- iUnitFlags  in  NUM_UNITS*3  per-unit {neg,ov,zero}.
- oResValid  out  1  FIFO head valid.
- iResReady  in  1  consumer accepts head.
- oResData  out  DATA_W  head result.
- oResTag  out  TAG_W  head tag.
- oResUnit  out  SEL_W  head unit index.
- oResFlags  out  3  head {neg,ov,zero}.
- oBusy  out  1  any op in flight or FIFO non-empty.

Behaviour:
- Reset: in-flight table, FIFO and count all cleared. oResValid=0, oBusy=0, oUnitFire=0, oResData/Tag/Unit/Flags=0. oIssueReady=0 while iRst=1.
- Issue accept: iIssueValid & oIssueReady. oIssueReady is combinational on iIssueUnit and state, never on iIssueValid. oUnitFire[u] is high in the accept cycle only.
- Latency L = UNIT_LAT[u]. An op accepted in cycle t has its result valid on iUnitResult/iUnitFlags[u] during cycle t+L. The block writes it into the FIFO at the end of cycle t+L; oResValid rises in t+L+1 at the earliest.
- Reservation: MAX_LAT-entry countdown table {valid, unit, tag, remaining}, decremented every cycle; an entry at remaining 0 is captured. oIssueReady=0 if either:
  - another entry would capture in cycle t+L (slot conflict), or
  - inflight + fifo_count >= FIFO_DEPTH (no credit).
- The FIFO therefore never overflows. Unit results outside reserved capture cycles are ignored.
- Illegal unit (iIssueUnit >= NUM_UNITS): accepted with L=1, no oUnitFire, captures data 0, flags 0, oResUnit = issued code.
- FIFO: push at capture and pop on oResValid & iResReady may occur in the same cycle; count unchanged. Outputs are driven from the head register and hold stable while oResValid & !iResReady.
- Ordering: results leave in completion order; the tag identifies each op.
- Reset mid-operation: all in-flight ops are discarded and never appear on the output; oBusy=0 the cycle after iRst.

Optional Feature:
- EXU_INORDER_EN defined: issue also requires L greater than the remaining count of every valid in-flight entry, so results leave in issue order. An entry capturing in the current cycle counts as remaining 0.
- Undefined: out-of-order completion as above.

Test Plan:
- Reset: hold iRst 2 cycles, then release → oResValid=0, oBusy=0, oIssueReady=1 in the first cycle after release.
- Single ALU: issue unit 0 tag 3 in cycle 0, iUnitResult[0]=32'h0000_0005 with flags 3'b000 in cycle 1 → oUnitFire=3'b001 in cycle 0; oResValid, oResData=5, oResTag=3, oResUnit=0 in cycle 2.
- Slot conflict: MDU tag 1 in cycle 0, ALU tag 2 requested in cycle 3 → oIssueReady=0 in cycle 3; ALU accepted in cycle 4. Tag 1 out in cycle 5, tag 2 out in cycle 6.
- Backpressure: iResReady=0, 4 ALU issues in cycles 0-3 → cycle 4 oIssueReady=0; iResReady=1 for one cycle → oIssueReady=1 the next cycle.
- Reordering: MDU tag 1 in cycle 0, ALU tag 2 in cycle 1 → tag 2 out in cycle 3, tag 1 out in cycle 5. With EXU_INORDER_EN: ALU stalled until cycle 4, tag 1 out in cycle 5, tag 2 out in cycle 6.
- Reset mid-op: MDU issued in cycle 0, iRst=1 in cycle 2 → no oResValid afterwards, oBusy=0 from cycle 3.
